// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, flag bit positions and opcodes.
// Imported by the ALU, its result stage and the benches.
package alu_pkg;
    localparam int ALU_DATA_W = 16;
    localparam int ALU_OP_W   = 3;

    localparam int FLAG_Z  = 0;
    localparam int FLAG_N  = 1;
    localparam int FLAG_C  = 2;
    localparam int FLAG_P  = 3;
    localparam int FLAGS_W = 4;

    typedef logic [FLAGS_W-1:0] flags_t;

    localparam logic [ALU_OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] OP_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [ALU_OP_W-1:0] OP_NOT = 3'b101;
    localparam logic [ALU_OP_W-1:0] OP_SHL = 3'b110;
    localparam logic [ALU_OP_W-1:0] OP_SHR = 3'b111;
endpackage

// File: rtl/alu_result_stage_if.sv
// Valid/ready bus between the ALU, the result stage and its consumer.
// master drives results in and takes them out; slave is the stage.
interface alu_result_stage_if
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] in_result;
    logic [DATA_W:0]   in_carry;

    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   out_op;
    logic [DATA_W-1:0] out_result;
    flags_t            out_flags;

    modport master (
        output in_valid, in_op, in_result, in_carry, out_ready,
        input  in_ready, out_valid, out_op, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_op, in_result, in_carry, out_ready,
        output in_ready, out_valid, out_op, out_result, out_flags
    );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational status flags {P,C,N,Z} from an ALU result and carry vector.
// Only the carry out of the top bit matters; lower carries are ignored.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W:0]   carry,
    output flags_t            flags
);
    logic unused_carry;

    assign unused_carry = ^carry[DATA_W-1:0];

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = result[DATA_W-1];
        flags[FLAG_C] = carry[DATA_W];
        flags[FLAG_P] = ^result;
    end
endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: tags results with flags and buffers them
// in a small first-word-fall-through FIFO behind a valid/ready handshake.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int DEPTH  = 4,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    alu_result_stage_if.slave        bus,
    output logic [$clog2(DEPTH):0]   out_count,
    output logic [15:0]              accept_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [OP_W-1:0]   op_mem  [DEPTH];
    logic [DATA_W-1:0] res_mem [DEPTH];
    flags_t            flg_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    flags_t        in_flags;
    logic          push;
    logic          pop;

    alu_flag_gen #(
        .DATA_W (DATA_W)
    ) u_flag_gen (
        .result (bus.in_result),
        .carry  (bus.in_carry),
        .flags  (in_flags)
    );

    assign bus.in_ready  = (count != CW'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Head is masked so stale storage never leaks after a flush.
    assign bus.out_op     = bus.out_valid ? op_mem[rd_ptr]  : '0;
    assign bus.out_result = bus.out_valid ? res_mem[rd_ptr] : '0;
    assign bus.out_flags  = bus.out_valid ? flg_mem[rd_ptr] : '0;

    assign out_count = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_mem[i]  <= '0;
                res_mem[i] <= '0;
                flg_mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            accept_cnt <= '0;
        end else if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            accept_cnt <= '0;
        end else begin
            if (push) begin
                op_mem[wr_ptr]  <= bus.in_op;
                res_mem[wr_ptr] <= bus.in_result;
                flg_mem[wr_ptr] <= in_flags;
                wr_ptr          <= wr_ptr + AW'(1);
                if (accept_cnt != 16'hFFFF) begin
                    accept_cnt <= accept_cnt + 16'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized self-checking bench for alu_result_stage against a
// queue-based reference model plus the directed scenarios.
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int DW    = 16;
    localparam int OW    = 3;
    localparam int DEPTH = 4;

    typedef struct {
        logic [OW-1:0] op;
        logic [DW-1:0] res;
        logic [3:0]    flg;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [2:0]  out_count;
    logic [15:0] accept_cnt;

    ent_t        q[$];
    int unsigned acc_m;
    int          checks;
    int          failures;

    alu_result_stage_if #(.DATA_W(DW), .OP_W(OW)) bus ();

    alu_result_stage #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .OP_W   (OW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .bus        (bus),
        .out_count  (out_count),
        .accept_cnt (accept_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_flags(input logic [DW-1:0] r,
                                             input logic [DW:0] c);
        int   ones;
        logic p, cy, n, z;
        ones = $countones(r);
        p    = (ones % 2) == 1;
        cy   = c >= 17'h10000;
        n    = r >= 16'h8000;
        z    = r == 16'h0000;
        return {p, cy, n, z};
    endfunction

    task automatic check_outs(input string tag);
        logic v;
        v = q.size() != 0;
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(q.size() != DEPTH));
        chk({tag, ".count"}, 32'(out_count), 32'(q.size()));
        chk({tag, ".accept"}, 32'(accept_cnt), acc_m);
        chk({tag, ".op"}, 32'(bus.out_op), v ? 32'(q[0].op) : 32'd0);
        chk({tag, ".result"}, 32'(bus.out_result), v ? 32'(q[0].res) : 32'd0);
        chk({tag, ".flags"}, 32'(bus.out_flags), v ? 32'(q[0].flg) : 32'd0);
    endtask

    task automatic step(input string tag, input logic v,
                        input logic [OW-1:0] op, input logic [DW-1:0] r,
                        input logic [DW:0] c, input logic rdy,
                        input logic cl, output logic took);
        bit can_push;
        bit can_pop;
        check_outs(tag);
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_result = r;
        bus.in_carry  = c;
        bus.out_ready = rdy;
        clr           = cl;
        took          = 1'b0;
        if (cl) begin
            q.delete();
            acc_m = 0;
        end else begin
            can_push = q.size() < DEPTH;
            can_pop  = q.size() > 0;
            if (can_pop && rdy) void'(q.pop_front());
            if (v && can_push) begin
                q.push_back('{op, r, ref_flags(r, c)});
                took = 1'b1;
                if (acc_m < 65535) acc_m++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    logic          took;
    logic          pend;
    logic          rv;
    logic          rrdy;
    logic          rcl;
    logic [OW-1:0] rop;
    logic [DW-1:0] rres;
    logic [DW:0]   rcar;
    int unsigned   acc0;

    initial begin
        checks   = 0;
        failures = 0;
        acc_m    = 0;
        rst_n    = 1'b0;
        clr      = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = OP_XOR;
        bus.in_result = 16'h1111;
        bus.in_carry  = 17'h0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.count", 32'(out_count), 32'd0);
        chk("rst.accept", 32'(accept_cnt), 32'd0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        step("single", 1, OP_ADD, 16'hAAA9, 17'h1FFFE, 0, 0, took);
        chk("single.flags_k", 32'(bus.out_flags), 32'h6);
        chk("single.result_k", 32'(bus.out_result), 32'hAAA9);
        chk("single.count_k", 32'(out_count), 32'd1);
        step("single.pop", 0, 0, 0, 0, 1, 0, took);

        step("zero", 1, OP_SUB, 16'h0000, 17'h00000, 0, 0, took);
        chk("zero.flags_k", 32'(bus.out_flags), 32'h1);
        step("zero.pop", 0, 0, 0, 0, 1, 0, took);

        for (int i = 1; i <= 4; i++)
            step("fill", 1, OP_OR, 16'(i), 17'h0, 0, 0, took);
        chk("full.in_ready_k", 32'(bus.in_ready), 32'd0);
        chk("full.count_k", 32'(out_count), 32'd4);
        step("full.hold", 1, OP_OR, 16'h0005, 17'h0, 0, 0, took);
        chk("full.held", 32'(took), 32'd0);
        chk("full.head_k", 32'(bus.out_result), 32'h0001);
        step("full.pop", 1, OP_OR, 16'h0005, 17'h0, 1, 0, took);
        chk("full.no_push_on_pop", 32'(took), 32'd0);
        step("full.retry", 1, OP_OR, 16'h0005, 17'h0, 0, 0, took);
        chk("full.accepted", 32'(took), 32'd1);
        for (int i = 2; i <= 5; i++) begin
            chk("drain.order", 32'(bus.out_result), 32'(i));
            step("drain", 0, 0, 0, 0, 1, 0, took);
        end
        chk("drain.empty", 32'(bus.out_valid), 32'd0);
        step("empty.pop", 0, 0, 0, 0, 1, 0, took);

        step("cc.fill", 1, OP_AND, 16'h0100, 17'h10000, 0, 0, took);
        step("cc.fill", 1, OP_AND, 16'h0101, 17'h10000, 0, 0, took);
        acc0 = acc_m;
        for (int i = 0; i < 8; i++) begin
            chk("cc.order", 32'(bus.out_result), 32'(16'h0100 + i));
            step("cc", 1, OP_AND, 16'(16'h0102 + i), 17'h0, 1, 0, took);
            chk("cc.count_k", 32'(out_count), 32'd2);
        end
        chk("cc.accept_delta", 32'(accept_cnt) - acc0, 32'd8);

        for (int i = 0; i < 3; i++)
            step("fl.fill", 1, OP_NOT, 16'(16'hF000 + i), 17'h0, 0, 0, took);
        step("fl.clr", 1, OP_NOT, 16'hDEAD, 17'h0, 1, 1, took);
        chk("fl.count_k", 32'(out_count), 32'd0);
        chk("fl.valid_k", 32'(bus.out_valid), 32'd0);
        chk("fl.accept_k", 32'(accept_cnt), 32'd0);
        chk("fl.result_masked", 32'(bus.out_result), 32'd0);
        step("ar.fill", 1, OP_SHL, 16'h8001, 17'h1FFFF, 0, 0, took);
        step("ar.fill", 1, OP_SHR, 16'h7FFF, 17'h0, 0, 0, took);
        check_outs("ar.pre");
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar.valid_async", 32'(bus.out_valid), 32'd0);
        chk("ar.count_async", 32'(out_count), 32'd0);
        chk("ar.accept_async", 32'(accept_cnt), 32'd0);
        q.delete();
        acc_m = 0;
        @(negedge clk);
        rst_n = 1'b1;

        pend = 1'b0;
        rv = 0; rop = 0; rres = 0; rcar = 0;
        for (int i = 0; i < 500; i++) begin
            if (!pend) begin
                rv   = $urandom_range(0, 3) != 0;
                rop  = 3'($urandom);
                rres = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
                rcar = 17'($urandom);
            end
            rrdy = $urandom_range(0, 2) != 0;
            rcl  = $urandom_range(0, 39) == 0;
            step("rnd", rv, rop, rres, rcar, rrdy, rcl, took);
            pend = rv && !took && !rcl;
        end

        step("sat.clr", 0, 0, 0, 0, 0, 1, took);
        bus.in_valid  = 1'b1;
        bus.in_op     = OP_ADD;
        bus.in_result = 16'h1234;
        bus.in_carry  = 17'h10000;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 65534; i++) @(posedge clk);
        @(negedge clk);
        chk("sat.pre", 32'(accept_cnt), 32'hFFFE);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sat.cap", 32'(accept_cnt), 32'hFFFF);
        chk("sat.count", 32'(out_count), 32'd1);
        q.delete();
        q.push_back('{OP_ADD, 16'h1234, ref_flags(16'h1234, 17'h10000)});
        acc_m = 65535;
        step("sat.hold", 1, OP_SUB, 16'h8000, 17'h0, 0, 0, took);
        step("sat.end", 0, 0, 0, 0, 1, 0, took);
        check_outs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
